stopwatch_mmss: RTL and testbench
=================================

Name: stopwatch_mmss

Overview:
- MM:SS stopwatch that consumes the slow square wave from the lab clock divider (1 Hz from 50 MHz) as a tick input.
- Runs on the same fast clock as the divider, so the divider output is never used as a clock. It is rising-edge detected and used as a count enable.
- Produces BCD digits for the board display, plus run and terminal-count status.

Parameters:
- MAX_MIN, 59, highest minute value reached before terminal count (0..99).
- WRAP, 1, 1 = roll over to 00:00 and keep running; 0 = saturate at terminal value and enter DONE.

Ports:
- clk_in  input  1  system clock (same clock as the divider)
- reset  input  1  synchronous, active-low reset
- tick_in  input  1  divider output (level); each rising edge = one second
- start_stop  input  1  debounced button level; each rising edge toggles run/pause
- clear  input  1  synchronous clear, level-sensitive
- sec_ones  output  4  BCD 0..9
- sec_tens  output  4  BCD 0..5
- min_ones  output  4  BCD 0..9
- min_tens  output  4  BCD 0..MAX_MIN/10
- running  output  1  high while state = RUN
- term_pulse  output  1  one-cycle pulse when count passes MAX_MIN:59
- done  output  1  high while state = DONE (WRAP=0 only)

Behaviour:
- Reset (reset=0 at a clk_in edge):
  - all digits 0, state IDLE, running=0, term_pulse=0, done=0.
  - edge registers tick_q=1 and ss_q=1, so a high input at reset release is not a rising edge.
- Edge detect:
  - tick_q<=tick_in; tick_rise = tick_in & ~tick_q.
  - start_stop is handled the same way (ss_rise).
  - Digits update on the same clk_in edge that first samples tick_in high, so count latency is 1 cycle from tick_in rising.
- States:
  - IDLE: count 00:00. ss_rise -> RUN.
  - RUN: tick_rise increments. ss_rise -> PAUSE.
  - PAUSE: count held. ss_rise -> RUN.
  - DONE: count frozen at MAX_MIN:59. ss_rise ignored; only clear or reset exits.
- Increment chain:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - minutes compare against MAX_MIN as a two-digit BCD value.
- Terminal (count = MAX_MIN:59 and tick_rise in RUN):
  - term_pulse=1 for exactly one cycle.
  - WRAP=1: count -> 00:00, stays in RUN.
  - WRAP=0: count holds, state -> DONE, done=1.
- Priority:
  - reset > clear > ss_rise/tick_rise.
  - clear=1: count 00:00, state IDLE, term_pulse=0, regardless of other inputs. Held clear keeps the block in IDLE.
- Simultaneous ss_rise and tick_rise:
  - in RUN: the tick is counted and state -> PAUSE.
  - in IDLE/PAUSE: state -> RUN and the tick is NOT counted, because the state decision uses the pre-edge state.
- tick_rise outside RUN is discarded and not queued.
- tick_in high for many cycles counts once. tick_in toggling every cycle counts on every second cycle.
- Outputs are registered; no combinational path from inputs to outputs (except seg outputs, which decode registered digits).

Optional Feature:
- SEVEN_SEG_EN defined:
  - adds outputs seg_s1, seg_s10, seg_m1, seg_m10, each 7 bits, active-low (segment a = bit 0).
  - each is decoded from the matching digit; values 10..15 blank all segments (7'h7F).
  - decoding is combinational from the digit registers.
- Not defined: seg ports and decoders are absent; BCD outputs are unchanged.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3)
  - BCD digit width constant (4)
  - seven-segment pattern constants for 0..9 and BLANK.
- One natural sub-module: bcd_to_7seg (4-bit BCD in, 7-bit active-low segments out), instantiated four times only under SEVEN_SEG_EN.
- The carry chain stays inline.

Test Plan:
- Reset release with tick_in=1, start_stop=1 -> no count, state IDLE, all outputs 0. Pulse start_stop (0 then 1), then 3 tick_in rises -> running=1, count 00:03, each update 1 cycle after tick_in rises.
- Preload by ticking to 00:59, then one tick_rise -> 01:00. At 09:59, one tick -> 10:00.
- WRAP=1, MAX_MIN=1: from 01:59 one tick -> 00:00, term_pulse high exactly 1 cycle, running stays 1. WRAP=0: same stimulus -> count holds 01:59, done=1; further ticks and start_stop rises have no effect; clear -> 00:00, IDLE.
- ss_rise and tick_rise on the same cycle: in RUN at 00:05 -> 00:06 and PAUSE; in PAUSE at 00:06 -> 00:06 and RUN.
- clear asserted together with tick_rise in RUN at 00:10 -> 00:00, IDLE, term_pulse=0. reset asserted mid-run at 03:27 -> all zero on the next edge.
- SEVEN_SEG_EN: count 00:08 -> seg_s1 = 7'h00 (all segments on for 8), seg_s10 = 7'h40 (0). Forced digit 4'hA via bench force -> 7'h7F.

Source files
------------

// File: rtl/stopwatch_mmss_pkg.sv
// rtl/stopwatch_mmss_pkg.sv - state encoding, digit width and seven-segment patterns for stopwatch_mmss
package stopwatch_mmss_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    // Active-low segments, segment a on bit 0, g on bit 6.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/stopwatch_mmss_if.sv
// rtl/stopwatch_mmss_if.sv - control/status bundle of stopwatch_mmss; seg outputs only with SEVEN_SEG_EN
interface stopwatch_mmss_if;
    import stopwatch_mmss_pkg::*;

    logic tick_in;
    logic start_stop;
    logic clear;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
    bcd_t min_tens;
    logic running;
    logic term_pulse;
    logic done;
`ifdef SEVEN_SEG_EN
    logic [6:0] seg_s1;
    logic [6:0] seg_s10;
    logic [6:0] seg_m1;
    logic [6:0] seg_m10;

    modport master (
        output tick_in, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, term_pulse, done,
        input  seg_s1, seg_s10, seg_m1, seg_m10
    );
    modport slave (
        input  tick_in, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, term_pulse, done,
        output seg_s1, seg_s10, seg_m1, seg_m10
    );
`else
    modport master (
        output tick_in, start_stop, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, term_pulse, done
    );
    modport slave (
        input  tick_in, start_stop, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, term_pulse, done
    );
`endif
endinterface

// File: rtl/stopwatch_mmss_bcd_to_7seg.sv
// rtl/stopwatch_mmss_bcd_to_7seg.sv - BCD digit to active-low seven-segment pattern; 10..15 blank
module stopwatch_mmss_bcd_to_7seg
    import stopwatch_mmss_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_mmss.sv
// rtl/stopwatch_mmss.sv - MM:SS BCD stopwatch counting rising edges of a slow tick level
// SEVEN_SEG_EN adds four active-low seven-segment decoders on the digit registers.
module stopwatch_mmss
    import stopwatch_mmss_pkg::*;
#(
    parameter int MAX_MIN = 59,
    parameter bit WRAP    = 1'b1
) (
    input  logic            clk_in,
    input  logic            reset,
    stopwatch_mmss_if.slave sw
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX_MIN % 10);

    sw_state_e state_q, state_d;
    bcd_t      sec_ones_q, sec_ones_d;
    bcd_t      sec_tens_q, sec_tens_d;
    bcd_t      min_ones_q, min_ones_d;
    bcd_t      min_tens_q, min_tens_d;
    logic      term_q, term_d;
    logic      running_q, done_q;
    logic      tick_q, ss_q;
    logic      tick_rise, ss_rise, at_term;

    assign tick_rise = sw.tick_in & ~tick_q;
    assign ss_rise   = sw.start_stop & ~ss_q;
    assign at_term   = (min_tens_q == MAX_TENS) && (min_ones_q == MAX_ONES) &&
                       (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        term_d     = 1'b0;
        if (sw.clear) begin
            state_d    = ST_IDLE;
            sec_ones_d = '0;
            sec_tens_d = '0;
            min_ones_d = '0;
            min_tens_d = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (ss_rise) state_d = ST_RUN;
                ST_PAUSE: if (ss_rise) state_d = ST_RUN;
                ST_RUN: begin
                    if (tick_rise) begin
                        if (at_term) begin
                            term_d = 1'b1;
                            if (WRAP) begin
                                sec_ones_d = '0;
                                sec_tens_d = '0;
                                min_ones_d = '0;
                                min_tens_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else if (sec_ones_q != 4'd9) begin
                            sec_ones_d = sec_ones_q + 4'd1;
                        end else begin
                            sec_ones_d = '0;
                            if (sec_tens_q != 4'd5) begin
                                sec_tens_d = sec_tens_q + 4'd1;
                            end else begin
                                sec_tens_d = '0;
                                if (min_ones_q != 4'd9) begin
                                    min_ones_d = min_ones_q + 4'd1;
                                end else begin
                                    min_ones_d = '0;
                                    min_tens_d = min_tens_q + 4'd1;
                                end
                            end
                        end
                    end
                    // A terminal hit without wrap wins over a simultaneous pause request.
                    if (ss_rise && state_d == ST_RUN) state_d = ST_PAUSE;
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            term_q     <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b1;
            ss_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            term_q     <= term_d;
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
            tick_q     <= sw.tick_in;
            ss_q       <= sw.start_stop;
        end
    end

    assign sw.sec_ones   = sec_ones_q;
    assign sw.sec_tens   = sec_tens_q;
    assign sw.min_ones   = min_ones_q;
    assign sw.min_tens   = min_tens_q;
    assign sw.running    = running_q;
    assign sw.done       = done_q;
    assign sw.term_pulse = term_q;

`ifdef SEVEN_SEG_EN
    stopwatch_mmss_bcd_to_7seg u_seg_s1  (.digit_i(sec_ones_q), .seg_o(sw.seg_s1));
    stopwatch_mmss_bcd_to_7seg u_seg_s10 (.digit_i(sec_tens_q), .seg_o(sw.seg_s10));
    stopwatch_mmss_bcd_to_7seg u_seg_m1  (.digit_i(min_ones_q), .seg_o(sw.seg_m1));
    stopwatch_mmss_bcd_to_7seg u_seg_m10 (.digit_i(min_tens_q), .seg_o(sw.seg_m10));
`endif

endmodule

// File: tb/tb_stopwatch_mmss.sv
// tb/tb_stopwatch_mmss.sv - scoreboard bench driving three stopwatch_mmss configs with shared stimulus
module tb_stopwatch_mmss;

    logic clk;
    logic rstn;
    logic tick;
    logic ss;
    logic clr;

    stopwatch_mmss_if ifa ();
    stopwatch_mmss_if ifb ();
    stopwatch_mmss_if ifc ();

    assign ifa.tick_in = tick;  assign ifa.start_stop = ss;  assign ifa.clear = clr;
    assign ifb.tick_in = tick;  assign ifb.start_stop = ss;  assign ifb.clear = clr;
    assign ifc.tick_in = tick;  assign ifc.start_stop = ss;  assign ifc.clear = clr;

    stopwatch_mmss #(.MAX_MIN(59), .WRAP(1'b1)) dut_a (.clk_in(clk), .reset(rstn), .sw(ifa));
    stopwatch_mmss #(.MAX_MIN(1),  .WRAP(1'b1)) dut_b (.clk_in(clk), .reset(rstn), .sw(ifb));
    stopwatch_mmss #(.MAX_MIN(1),  .WRAP(1'b0)) dut_c (.clk_in(clk), .reset(rstn), .sw(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [18:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt[3];
    int   st[3];
    int   maxm[3] = '{59, 1, 1};
    bit   wrp[3]  = '{1'b1, 1'b1, 1'b0};
    logic tprev;
    logic sprev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // {min_tens, min_ones, sec_tens, sec_ones, running, done, term_pulse}
    function automatic logic [18:0] obs(input int i);
        case (i)
            0: return {ifa.min_tens, ifa.min_ones, ifa.sec_tens, ifa.sec_ones, ifa.running, ifa.done, ifa.term_pulse};
            1: return {ifb.min_tens, ifb.min_ones, ifb.sec_tens, ifb.sec_ones, ifb.running, ifb.done, ifb.term_pulse};
            default: return {ifc.min_tens, ifc.min_ones, ifc.sec_tens, ifc.sec_ones, ifc.running, ifc.done, ifc.term_pulse};
        endcase
    endfunction

    // Drive one cycle of inputs, push the expected post-edge outputs, then compare after the edge.
    task automatic drive(input logic t, input logic s, input logic c, input logic r);
        logic tr, sr, nt;
        sb_t  e;
        tick = t; ss = s; clr = c; rstn = r;
        tr = t & ~tprev;
        sr = s & ~sprev;
        for (int i = 0; i < 3; i++) begin
            nt = 1'b0;
            if (!r || c) begin
                cnt[i] = 0;
                st[i]  = 0;
            end else if (st[i] == 1) begin
                if (tr) begin
                    if (cnt[i] == maxm[i] * 60 + 59) begin
                        nt = 1'b1;
                        if (wrp[i]) cnt[i] = 0;
                        else        st[i]  = 3;
                    end else begin
                        cnt[i]++;
                    end
                end
                if (sr && st[i] == 1) st[i] = 2;
            end else if (st[i] != 3 && sr) begin
                st[i] = 1;
            end
            e.idx = i;
            e.exp = {to_bcd(cnt[i]), st[i] == 1, st[i] == 3, nt};
            sb_q.push_back(e);
        end
        if (!r) begin
            tprev = 1'b1;
            sprev = 1'b1;
        end else begin
            tprev = t;
            sprev = s;
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("sb_dut%0d", e.idx), 32'(obs(e.idx)), 32'(e.exp));
        end
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, ss, 1'b0, 1'b1);
            drive(1'b0, ss, 1'b0, 1'b1);
        end
    endtask

    task automatic press();
        drive(tick, 1'b0, 1'b0, 1'b1);
        drive(tick, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        tick = 1'b1; ss = 1'b1; clr = 1'b0; rstn = 1'b0;
        tprev = 1'b1; sprev = 1'b1;
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; st[i] = 0; end

        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("release_high_idle", 32'(obs(0)), 32'h0);

        press();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick_n(3);
        check("count_0003_run", 32'(obs(0)), {13'h0, 16'h0003, 3'b100});

        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick_n(1);
        check("held_tick_once", 32'(obs(0)), {13'h0, 16'h0005, 3'b100});

        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("run_ss_tick_pause", 32'(obs(0)), {13'h0, 16'h0006, 3'b000});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("pause_ss_tick_run", 32'(obs(0)), {13'h0, 16'h0006, 3'b100});
        drive(1'b0, 1'b1, 1'b0, 1'b1);

        tick_n(4);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_with_tick", 32'(obs(0)), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);

        press();
        tick_n(59);
        check("count_0059", 32'(obs(0)), {13'h0, 16'h0059, 3'b100});
        tick_n(1);
        check("count_0100", 32'(obs(0)), {13'h0, 16'h0100, 3'b100});
        tick_n(147);
        check("done_c_hold", 32'(obs(2)), {13'h0, 16'h0159, 3'b010});
        press();
        press();
        check("done_ignores_ss", 32'(obs(2)), {13'h0, 16'h0159, 3'b010});
        check("count_0327", 32'(obs(0)), {13'h0, 16'h0327, 3'b100});

        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_midrun", 32'(obs(0)), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);

        press();
        tick_n(599);
        check("count_0959", 32'(obs(0)), {13'h0, 16'h0959, 3'b100});
        tick_n(1);
        check("count_1000", 32'(obs(0)), {13'h0, 16'h1000, 3'b100});
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_exits_done", 32'(obs(2)), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);

`ifdef SEVEN_SEG_EN
        press();
        tick_n(8);
        check("seg_s1_8", 32'(ifa.seg_s1), 32'h00);
        check("seg_s10_0", 32'(ifa.seg_s10), 32'h40);
        force dut_a.sec_ones_q = 4'hA;
        #1;
        check("seg_blank_a", 32'(ifa.seg_s1), 32'h7F);
        release dut_a.sec_ones_q;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
